store_buffer_ctrl: RTL and testbench

//  Circular store buffer between the load/store unit and the L1d cache. Dispatch allocates

---
 rtl/store_buffer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_store_buffer_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_ctrl.sv
// Circular store buffer: in-order allocation, LSU fill, ROB commit, in-order drain to L1d
// over req/ack, zero-latency store-to-load forwarding and flush of uncommitted entries.
module store_buffer_ctrl #(
    parameter int DEPTH = 32,
    parameter int IDXW  = 5,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    output logic [IDXW-1:0] alloc_idx,
    output logic            sb_full,
    output logic            sb_empty,
    input  logic            SB_W,
    input  logic [IDXW-1:0] SB_index,
    input  logic [AW-1:0]   SB_addr,
    input  logic [DW-1:0]   SB_wdata,
    input  logic            commit,
    input  logic            flush,
    input  logic [AW-1:0]   SB_search_addr,
    output logic            SB_match,
    output logic [DW-1:0]   SB_data,
    output logic            l1d_wr_req,
    output logic [AW-1:0]   l1d_wr_addr,
    output logic [DW-1:0]   l1d_wr_data,
    input  logic            l1d_wr_ack
);

    typedef enum logic {IDLE, REQ} drain_t;

    drain_t          state_q, state_d;
    logic [IDXW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [IDXW:0]   count_q, count_d, ucnt_q, ucnt_d;
    logic [DEPTH-1:0] valid_q, valid_d, res_q, res_d, cmtd_q, cmtd_d;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [AW-1:0]   addr_d [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];
    logic            req_q, req_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            alloc_acc, commit_acc, ack_acc, wr_ok;
    logic [IDXW-1:0] pos;

    assign sb_full     = (count_q == (IDXW+1)'(DEPTH));
    assign sb_empty    = (count_q == '0);
    assign alloc_idx   = tail_q;
    assign l1d_wr_req  = req_q;
    assign l1d_wr_addr = wr_addr_q;
    assign l1d_wr_data = wr_data_q;

    always_comb begin
        head_d     = head_q;
        cmt_d      = cmt_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        res_d      = res_q;
        cmtd_d     = cmtd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ack_acc    = (state_q == REQ) && l1d_wr_ack;
        alloc_acc  = alloc_req && !sb_full && !flush;
        // ucnt tracks uncommitted entries, so commit stays legal when full and none committed
        commit_acc = commit && (ucnt_q != '0);
        ucnt_d     = ucnt_q - {{IDXW{1'b0}}, commit_acc};
        if (commit_acc) begin
            cmtd_d[cmt_q] = 1'b1;
            cmt_d         = cmt_q + 1'b1;
        end
        wr_ok = SB_W && valid_q[SB_index] && (!flush || cmtd_d[SB_index]);
        if (wr_ok) begin
            addr_d[SB_index] = SB_addr;
            data_d[SB_index] = SB_wdata;
            res_d[SB_index]  = 1'b1;
        end
        if (ack_acc) begin
            valid_d[head_q] = 1'b0;
            cmtd_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (flush) begin
            valid_d = valid_d & cmtd_d;
            tail_d  = cmt_d;
            count_d = count_q - ucnt_d - {{IDXW{1'b0}}, ack_acc};
            ucnt_d  = '0;
        end else begin
            if (alloc_acc) begin
                valid_d[tail_q] = 1'b1;
                res_d[tail_q]   = 1'b0;
                cmtd_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
                ucnt_d          = ucnt_d + 1'b1;
            end
            count_d = count_q + {{IDXW{1'b0}}, alloc_acc} - {{IDXW{1'b0}}, ack_acc};
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (valid_q[head_q] && cmtd_q[head_q] && res_q[head_q]) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    wr_addr_d = addr_q[head_q];
                    wr_data_d = data_q[head_q];
                end
            end
            REQ: begin
                if (l1d_wr_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan oldest to youngest so the last hit is the entry nearest tail
    always_comb begin
        SB_match = 1'b0;
        SB_data  = '0;
        pos      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head_q + IDXW'(i);
            if (valid_q[pos] && res_q[pos] && (addr_q[pos] == SB_search_addr)) begin
                SB_match = 1'b1;
                SB_data  = data_q[pos];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ucnt_q    <= '0;
            valid_q   <= '0;
            res_q     <= '0;
            cmtd_q    <= '0;
            req_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ucnt_q    <= ucnt_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            cmtd_q    <= cmtd_d;
            req_q     <= req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Entry payload is qualified by the flags, so it carries no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl: directed vector table, hand-written drain/reset
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_store_buffer_ctrl;

    logic        clk, rst;
    logic        alloc_req, SB_W, commit, flush, l1d_wr_ack;
    logic [4:0]  SB_index;
    logic [15:0] SB_addr, SB_wdata, SB_search_addr;
    logic [4:0]  alloc_idx;
    logic        sb_full, sb_empty, SB_match, l1d_wr_req;
    logic [15:0] SB_data, l1d_wr_addr, l1d_wr_data;

    int total = 0;
    int bad   = 0;

    store_buffer_ctrl dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_idx(alloc_idx),
        .sb_full(sb_full), .sb_empty(sb_empty), .SB_W(SB_W), .SB_index(SB_index),
        .SB_addr(SB_addr), .SB_wdata(SB_wdata), .commit(commit), .flush(flush),
        .SB_search_addr(SB_search_addr), .SB_match(SB_match), .SB_data(SB_data),
        .l1d_wr_req(l1d_wr_req), .l1d_wr_addr(l1d_wr_addr), .l1d_wr_data(l1d_wr_data),
        .l1d_wr_ack(l1d_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: entries held oldest-first in a queue
    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [15:0] data;
        bit          res;
        bit          cmt;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          m_req;
    logic [15:0] m_ra, m_rd;

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_req  = 1'b0;
        m_ra   = '0;
        m_rd   = '0;
    endtask

    task automatic model_step();
        bit   ack_acc, start, full0, done;
        ent_t h;
        ent_t e;
        int   n;
        ack_acc = m_req && l1d_wr_ack;
        start   = !m_req && (q.size() > 0) && q[0].cmt && q[0].res;
        full0   = (q.size() == 32);
        if (q.size() > 0) h = q[0];
        if (commit) begin
            done = 1'b0;
            for (int i = 0; i < q.size(); i++)
                if (!done && !q[i].cmt) begin
                    q[i].cmt = 1'b1;
                    done = 1'b1;
                end
        end
        if (SB_W)
            for (int i = 0; i < q.size(); i++)
                if (q[i].idx == int'(SB_index) && (!flush || q[i].cmt)) begin
                    q[i].addr = SB_addr;
                    q[i].data = SB_wdata;
                    q[i].res  = 1'b1;
                end
        if (flush) begin
            n = 0;
            while (q.size() > 0 && !q[q.size()-1].cmt) begin
                void'(q.pop_back());
                n++;
            end
            m_tail = (m_tail - n) & 31;
        end else if (alloc_req && !full0) begin
            e.idx = m_tail; e.addr = '0; e.data = '0; e.res = 1'b0; e.cmt = 1'b0;
            q.push_back(e);
            m_tail = (m_tail + 1) % 32;
        end
        if (ack_acc) begin
            void'(q.pop_front());
            m_req = 1'b0;
        end else if (start) begin
            m_req = 1'b1;
            m_ra  = h.addr;
            m_rd  = h.data;
        end
    endtask

    task automatic model_fwd(input logic [15:0] a, output bit m, output logic [15:0] d);
        m = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!m && q[i].res && q[i].addr == a) begin
                m = 1'b1;
                d = q[i].data;
            end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alloc_req = 0; SB_W = 0; commit = 0; flush = 0; l1d_wr_ack = 0;
        SB_index = '0; SB_addr = '0; SB_wdata = '0; SB_search_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        #2;
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_full", 32'(sb_full), 32'd0);
        chk("rst_idx", 32'(alloc_idx), 32'd0);
        chk("rst_req", 32'(l1d_wr_req), 32'd0);
        chk("rst_wr_addr", 32'(l1d_wr_addr), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!l1d_wr_req && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(l1d_wr_req), 32'd1);
    endtask

    typedef struct {
        bit          alloc;
        bit          w;
        logic [4:0]  widx;
        logic [15:0] waddr;
        logic [15:0] wdata;
        bit          fl;
        logic [15:0] srch;
        logic [4:0]  e_idx;
        bit          e_match;
        logic [15:0] e_data;
        bit          e_empty;
    } vec_t;

    vec_t vt[14];
    bit          mm;
    logic [15:0] md;

    initial begin
        vt[0]  = '{1, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0000, 5'd0, 0, 16'h0000, 1};
        vt[1]  = '{1, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0000, 5'd1, 0, 16'h0000, 0};
        vt[2]  = '{1, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0000, 5'd2, 0, 16'h0000, 0};
        vt[3]  = '{0, 1, 5'd1, 16'h0040, 16'hBEEF, 0, 16'h0040, 5'd3, 0, 16'h0000, 0};
        vt[4]  = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0040, 5'd3, 1, 16'hBEEF, 0};
        vt[5]  = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0042, 5'd3, 0, 16'h0000, 0};
        vt[6]  = '{0, 1, 5'd0, 16'h0010, 16'h1111, 0, 16'h0010, 5'd3, 0, 16'h0000, 0};
        vt[7]  = '{0, 1, 5'd1, 16'h0010, 16'h2222, 0, 16'h0010, 5'd3, 1, 16'h1111, 0};
        vt[8]  = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0010, 5'd3, 1, 16'h2222, 0};
        vt[9]  = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0040, 5'd3, 0, 16'h0000, 0};
        vt[10] = '{0, 1, 5'd5, 16'h0077, 16'h5555, 0, 16'h0077, 5'd3, 0, 16'h0000, 0};
        vt[11] = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0077, 5'd3, 0, 16'h0000, 0};
        vt[12] = '{0, 0, 5'd0, 16'h0000, 16'h0000, 1, 16'h0010, 5'd3, 1, 16'h2222, 0};
        vt[13] = '{0, 0, 5'd0, 16'h0000, 16'h0000, 0, 16'h0010, 5'd0, 0, 16'h0000, 1};

        idle_inputs();
        rst = 1'b1;
        model_reset();
        do_reset();

        // Allocation, forwarding, youngest-wins, invalid write, flush
        for (int i = 0; i < 14; i++) begin
            alloc_req = vt[i].alloc; SB_W = vt[i].w; SB_index = vt[i].widx;
            SB_addr = vt[i].waddr; SB_wdata = vt[i].wdata; flush = vt[i].fl;
            SB_search_addr = vt[i].srch;
            #2;
            chk($sformatf("vec%0d_idx", i), 32'(alloc_idx), 32'(vt[i].e_idx));
            chk($sformatf("vec%0d_match", i), 32'(SB_match), 32'(vt[i].e_match));
            chk($sformatf("vec%0d_data", i), 32'(SB_data), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_empty", i), 32'(sb_empty), 32'(vt[i].e_empty));
            chk($sformatf("vec%0d_req", i), 32'(l1d_wr_req), 32'd0);
            tick();
        end
        idle_inputs();

        // Fill to full, reject extra alloc, drain one, wrap
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1;
            #2;
            chk($sformatf("fill%0d_idx", i), 32'(alloc_idx), 32'(i));
            chk($sformatf("fill%0d_full", i), 32'(sb_full), 32'd0);
            tick();
        end
        alloc_req = 1;
        #2;
        chk("full_set", 32'(sb_full), 32'd1);
        tick();
        alloc_req = 0;
        #2;
        chk("full_hold", 32'(sb_full), 32'd1);
        chk("full_tail", 32'(alloc_idx), 32'd0);
        SB_W = 1; SB_index = 5'd0; SB_addr = 16'h0500; SB_wdata = 16'h0055; commit = 1;
        tick();
        idle_inputs();
        wait_req("full_drain_req");
        chk("full_drain_addr", 32'(l1d_wr_addr), 32'h0500);
        l1d_wr_ack = 1;
        tick();
        l1d_wr_ack = 0;
        #2;
        chk("full_clear", 32'(sb_full), 32'd0);
        chk("wrap_idx", 32'(alloc_idx), 32'd0);

        // Flush keeps committed entries, drops the rest
        do_reset();
        for (int i = 0; i < 4; i++) begin alloc_req = 1; tick(); end
        alloc_req = 0;
        for (int i = 0; i < 4; i++) begin
            SB_W = 1; SB_index = 5'(i); SB_addr = 16'h0100 + 16'(i); SB_wdata = 16'hA000 + 16'(i);
            tick();
        end
        SB_W = 0;
        commit = 1; tick(); tick(); commit = 0;
        flush = 1; tick(); flush = 0;
        SB_search_addr = 16'h0102;
        #2;
        chk("flush_tail", 32'(alloc_idx), 32'd2);
        chk("flush_gone", 32'(SB_match), 32'd0);
        SB_search_addr = 16'h0101;
        #1;
        chk("flush_kept", 32'(SB_match), 32'd1);
        chk("flush_kept_data", 32'(SB_data), 32'hA001);
        wait_req("flush_req0");
        chk("flush_drain0", 32'(l1d_wr_addr), 32'h0100);
        l1d_wr_ack = 1; tick(); l1d_wr_ack = 0;
        wait_req("flush_req1");
        chk("flush_drain1", 32'(l1d_wr_addr), 32'h0101);
        chk("flush_drain1_data", 32'(l1d_wr_data), 32'hA001);
        l1d_wr_ack = 1; tick(); l1d_wr_ack = 0;
        #2;
        chk("flush_empty", 32'(sb_empty), 32'd1);

        // Handshake: request held stable until ack
        do_reset();
        alloc_req = 1; tick(); alloc_req = 0;
        SB_W = 1; SB_index = 5'd0; SB_addr = 16'h0300; SB_wdata = 16'hC0DE; commit = 1;
        tick();
        idle_inputs();
        wait_req("hs_req");
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("hs_hold%0d_req", k), 32'(l1d_wr_req), 32'd1);
            chk($sformatf("hs_hold%0d_addr", k), 32'(l1d_wr_addr), 32'h0300);
            chk($sformatf("hs_hold%0d_data", k), 32'(l1d_wr_data), 32'hC0DE);
            tick();
        end
        l1d_wr_ack = 1;
        #2;
        chk("hs_ack_req", 32'(l1d_wr_req), 32'd1);
        tick();
        l1d_wr_ack = 0;
        #2;
        chk("hs_done_req", 32'(l1d_wr_req), 32'd0);
        chk("hs_done_empty", 32'(sb_empty), 32'd1);
        chk("hs_done_tail", 32'(alloc_idx), 32'd1);

        // Asynchronous reset abandons an outstanding request
        do_reset();
        alloc_req = 1; tick(); alloc_req = 0;
        SB_W = 1; SB_index = 5'd0; SB_addr = 16'h0700; SB_wdata = 16'h7777; commit = 1;
        tick();
        idle_inputs();
        wait_req("ar_req");
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req_low", 32'(l1d_wr_req), 32'd0);
        chk("ar_empty", 32'(sb_empty), 32'd1);
        chk("ar_addr", 32'(l1d_wr_addr), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        l1d_wr_ack = 1;
        tick();
        l1d_wr_ack = 0;
        #2;
        chk("ar_ack_ignored", 32'(l1d_wr_req), 32'd0);
        chk("ar_still_empty", 32'(sb_empty), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            alloc_req  = ($urandom_range(0, 9) < 6);
            SB_W       = ($urandom_range(0, 2) != 0);
            SB_index   = 5'((m_tail - 1 - int'($urandom_range(0, 6))) & 31);
            SB_addr    = 16'h0010 + 16'($urandom_range(0, 7));
            SB_wdata   = 16'($urandom);
            commit     = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            l1d_wr_ack = ($urandom_range(0, 1) == 1);
            SB_search_addr = 16'h0010 + 16'($urandom_range(0, 8));
            #2;
            model_fwd(SB_search_addr, mm, md);
            chk("rnd_idx", 32'(alloc_idx), 32'(m_tail));
            chk("rnd_full", 32'(sb_full), 32'(q.size() == 32));
            chk("rnd_empty", 32'(sb_empty), 32'(q.size() == 0));
            chk("rnd_match", 32'(SB_match), 32'(mm));
            chk("rnd_data", 32'(SB_data), 32'(md));
            chk("rnd_req", 32'(l1d_wr_req), 32'(m_req));
            if (m_req) begin
                chk("rnd_wr_addr", 32'(l1d_wr_addr), 32'(m_ra));
                chk("rnd_wr_data", 32'(l1d_wr_data), 32'(m_rd));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
